// File: rtl/mca_spectrum_tx.sv
// mca_spectrum_tx: streams one MCA spectrum from histogram RAM to a byte-wide
// transmitter. The frame is a header byte, then N_CH words sent MSB byte first,
// then an optional trailing checksum byte.
// Optional feature macro: MCA_TX_CHECKSUM_EN. When it is defined, the frame
// ends with an 8-bit sum (mod 256) of all data bytes; the header is excluded.
module mca_spectrum_tx #(
    parameter int          DATA_W   = 16,
    parameter int          N_CH     = 1024,
    parameter int          ADDR_W   = 10,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_in,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data
);

    localparam int                BYTES     = DATA_W / 8;
    localparam int                IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CH - 1);
    localparam logic [IDX_W-1:0]  TOP_IDX   = IDX_W'(BYTES - 1);

`ifdef MCA_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_WAIT, SEND, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_WAIT, SEND, DONE} state_t;
`endif

    state_t            state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [DATA_W-1:0] shreg_next;
    logic [IDX_W-1:0]  byte_idx_reg;
    logic              xfer;
`ifdef MCA_TX_CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    // A byte leaves on every edge where the handshake is complete.
    assign xfer = tx_valid && tx_ready;

    // The shift register always keeps the byte being sent in its top 8 bits,
    // so moving on to the next byte is a left shift.
    assign shreg_next = shreg_reg << 8;

    // Frame sequencer. All outputs are registered and come straight from this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            ram_addr     <= '0;
            ram_rd_en    <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            shreg_reg    <= '0;
            byte_idx_reg <= '0;
`ifdef MCA_TX_CHECKSUM_EN
            csum_reg     <= 8'h00;
`endif
        end else begin
            // Both strobes are single-cycle pulses.
            done      <= 1'b0;
            ram_rd_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= HDR;
                        ram_addr  <= '0;
                        busy      <= 1'b1;
                        tx_valid  <= 1'b1;
                        tx_data   <= HDR_BYTE;
`ifdef MCA_TX_CHECKSUM_EN
                        csum_reg  <= 8'h00;
`endif
                    end
                end
                HDR: begin
                    if (xfer) begin
                        tx_valid  <= 1'b0;
                        ram_rd_en <= 1'b1;
                        state_reg <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    // The read strobe is high during this cycle. Data arrives next cycle.
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    shreg_reg    <= ram_in;
                    byte_idx_reg <= TOP_IDX;
                    tx_valid     <= 1'b1;
                    tx_data      <= ram_in[DATA_W-1 -: 8];
                    state_reg    <= SEND;
                end
                SEND: begin
                    if (xfer) begin
`ifdef MCA_TX_CHECKSUM_EN
                        csum_reg <= csum_reg + tx_data;
`endif
                        if (byte_idx_reg != '0) begin
                            // Next byte of the same word, with no bubble.
                            byte_idx_reg <= byte_idx_reg - IDX_W'(1);
                            shreg_reg    <= shreg_next;
                            tx_data      <= shreg_next[DATA_W-1 -: 8];
                        end else if (ram_addr == LAST_ADDR) begin
`ifdef MCA_TX_CHECKSUM_EN
                            // The checksum byte includes the byte just sent.
                            tx_data   <= csum_reg + tx_data;
                            state_reg <= CHK;
`else
                            tx_valid  <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
`endif
                        end else begin
                            ram_addr  <= ram_addr + ADDR_W'(1);
                            tx_valid  <= 1'b0;
                            ram_rd_en <= 1'b1;
                            state_reg <= RD_REQ;
                        end
                    end
                end
`ifdef MCA_TX_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        tx_valid  <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
`endif
                DONE: begin
                    // start is not sampled here, so a request in this cycle is dropped.
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mca_spectrum_tx.sv
// Directed bench for mca_spectrum_tx. It uses three instances with different
// widths and channel counts. Each instance has a small registered-read RAM
// model and a monitor that records the bytes transferred, the read strobes
// and the done pulses.
module tb_mca_spectrum_tx;

`ifdef MCA_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: DATA_W=16, N_CH=4 ----------------
    logic        a_start = 1'b0, a_ready = 1'b1;
    logic        a_busy, a_done, a_rd, a_valid;
    logic [9:0]  a_addr;
    logic [15:0] a_ram_in;
    logic [7:0]  a_data;
    logic [15:0] a_mem [4] = '{16'h0001, 16'h1234, 16'hABCD, 16'hFFFF};
    logic [7:0]  exp_a [10] = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF, 8'hBD};

    always @(posedge clk) if (a_rd) a_ram_in <= a_mem[a_addr[1:0]];

    mca_spectrum_tx #(.DATA_W(16), .N_CH(4), .ADDR_W(10), .HDR_BYTE(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .ram_addr(a_addr), .ram_rd_en(a_rd), .ram_in(a_ram_in),
        .tx_ready(a_ready), .tx_valid(a_valid), .tx_data(a_data));

    logic [7:0] a_q [$];
    int         a_rd_q [$];
    int         a_done_cnt = 0;
    time        a_last_xfer_t = 0, a_done_t = 0;
    logic       a_stall_prev = 1'b0;
    logic [7:0] a_data_prev = 8'h00;

    // Monitor A: record transfers, reads and done pulses, and check that data holds while stalled.
    always @(posedge clk) begin
        if (!rst && a_stall_prev) begin
            check("a_stall_valid", {31'd0, a_valid}, 32'd1);
            check("a_stall_data", {24'd0, a_data}, {24'd0, a_data_prev});
        end
        a_stall_prev = a_valid && !a_ready && !rst;
        a_data_prev  = a_data;
        if (!rst && a_valid && a_ready) begin a_q.push_back(a_data); a_last_xfer_t = $time; end
        if (!rst && a_rd) a_rd_q.push_back(int'(a_addr));
        if (!rst && a_done) begin a_done_cnt++; a_done_t = $time; end
    end

    // ---------------- instance B: DATA_W=32, N_CH=1 ----------------
    logic        b_start = 1'b0, b_ready = 1'b1;
    logic        b_busy, b_done, b_rd, b_valid;
    logic [3:0]  b_addr;
    logic [31:0] b_ram_in;
    logic [7:0]  b_data;
    logic [7:0]  exp_b [6] = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};

    always @(posedge clk) if (b_rd) b_ram_in <= (b_addr == 4'd0) ? 32'hDEADBEEF : 32'h0;

    mca_spectrum_tx #(.DATA_W(32), .N_CH(1), .ADDR_W(4), .HDR_BYTE(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .ram_addr(b_addr), .ram_rd_en(b_rd), .ram_in(b_ram_in),
        .tx_ready(b_ready), .tx_valid(b_valid), .tx_data(b_data));

    logic [7:0] b_q [$];
    int         b_rd_q [$];
    int         b_done_cnt = 0;

    // Monitor B: record transfers, reads and done pulses.
    always @(posedge clk) begin
        if (!rst && b_valid && b_ready) b_q.push_back(b_data);
        if (!rst && b_rd) b_rd_q.push_back(int'(b_addr));
        if (!rst && b_done) b_done_cnt++;
    end

    // ---------------- instance C: DATA_W=8, N_CH=3 ----------------
    logic        c_start = 1'b0, c_ready = 1'b0;
    logic        c_busy, c_done, c_rd, c_valid;
    logic [1:0]  c_addr;
    logic [7:0]  c_ram_in;
    logic [7:0]  c_data;
    logic [7:0]  c_mem [4] = '{8'h10, 8'h20, 8'h30, 8'h00};
    logic [7:0]  exp_c [5] = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h60};

    always @(posedge clk) if (c_rd) c_ram_in <= c_mem[c_addr];

    mca_spectrum_tx #(.DATA_W(8), .N_CH(3), .ADDR_W(2), .HDR_BYTE(8'hA5)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
        .ram_addr(c_addr), .ram_rd_en(c_rd), .ram_in(c_ram_in),
        .tx_ready(c_ready), .tx_valid(c_valid), .tx_data(c_data));

    logic [7:0] c_q [$];
    int         c_rd_q [$];
    int         c_done_cnt = 0;

    // Monitor C: record transfers, reads and done pulses.
    always @(posedge clk) begin
        if (!rst && c_valid && c_ready) c_q.push_back(c_data);
        if (!rst && c_rd) c_rd_q.push_back(int'(c_addr));
        if (!rst && c_done) c_done_cnt++;
    end

    // Run one frame on A. mode 0: ready held high; 1: ready toggles every cycle;
    // 2: start is pulsed again at word 2 and also during the done cycle.
    task automatic run_a(input int mode, input string tag);
        logic repulsed;
        repulsed = 1'b0;
        a_q.delete();
        a_rd_q.delete();
        a_done_cnt = 0;
        a_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int c = 0; c < 400 && a_done_cnt == 0; c++) begin
            a_start = 1'b0;
            if (mode == 2 && a_addr == 10'd2 && !repulsed) begin a_start = 1'b1; repulsed = 1'b1; end
            if (mode == 2 && a_done) a_start = 1'b1;
            if (mode == 1) a_ready = ~a_ready;
            @(negedge clk);
        end
        a_start = 1'b0;
        a_ready = 1'b1;
        check({tag, "_done_seen"}, a_done_cnt, 1);
        check({tag, "_done_timing"}, 32'(a_done_t - a_last_xfer_t), 32'd10);
        repeat (4) @(negedge clk);
        check({tag, "_single_done"}, a_done_cnt, 1);
        check({tag, "_idle_busy"}, {31'd0, a_busy}, 32'd0);
        check({tag, "_nbytes"}, a_q.size(), 9 + CS);
        for (int i = 0; i < 9 + CS && i < a_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, a_q[i]}, {24'd0, exp_a[i]});
        check({tag, "_nreads"}, a_rd_q.size(), 4);
        for (int i = 0; i < 4 && i < a_rd_q.size(); i++)
            check($sformatf("%s_rdaddr%0d", tag, i), a_rd_q[i], i);
        $display("frame %s: %0d bytes, %0d reads, %0d done", tag, a_q.size(), a_rd_q.size(), a_done_cnt);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_done", {31'd0, a_done}, 32'd0);
        check("rst_addr", {22'd0, a_addr}, 32'd0);
        check("rst_rd_en", {31'd0, a_rd}, 32'd0);
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_data", {24'd0, a_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Main frame, then stalls, then start re-pulsed, then a follow-up frame
        run_a(0, "a_plain");
        run_a(1, "a_toggle");
        run_a(2, "a_repulse");
        run_a(0, "a_second");

        // Reset asserted during SEND of word 1
        a_done_cnt = 0;
        a_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int c = 0; c < 100 && !(a_addr == 10'd1 && a_valid); c++) @(negedge clk);
        check("abort_reached_word1", {31'd0, (a_addr == 10'd1 && a_valid)}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", {31'd0, a_valid}, 32'd0);
        check("abort_busy", {31'd0, a_busy}, 32'd0);
        check("abort_addr", {22'd0, a_addr}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", a_done_cnt, 0);
        $display("abort: valid=%0d busy=%0d addr=%0d", a_valid, a_busy, a_addr);
        run_a(0, "a_after_abort");

        // 32-bit word, single channel
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 100 && b_done_cnt == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("b_done_cnt", b_done_cnt, 1);
        check("b_nbytes", b_q.size(), 5 + CS);
        for (int i = 0; i < 5 + CS && i < b_q.size(); i++)
            check($sformatf("b_byte%0d", i), {24'd0, b_q[i]}, {24'd0, exp_b[i]});
        check("b_nreads", b_rd_q.size(), 1);
        if (b_rd_q.size() > 0) check("b_rdaddr0", b_rd_q[0], 0);
        $display("frame b: %0d bytes, %0d reads", b_q.size(), b_rd_q.size());

        // 8-bit words with the header held off for 5 cycles
        c_ready = 1'b0;
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        for (int c = 0; c < 20 && !c_valid; c++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("c_hold_valid%0d", i), {31'd0, c_valid}, 32'd1);
            check($sformatf("c_hold_data%0d", i), {24'd0, c_data}, 32'hA5);
            @(negedge clk);
        end
        check("c_no_early_read", c_rd_q.size(), 0);
        c_ready = 1'b1;
        for (int c = 0; c < 100 && c_done_cnt == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("c_done_cnt", c_done_cnt, 1);
        check("c_nbytes", c_q.size(), 4 + CS);
        for (int i = 0; i < 4 + CS && i < c_q.size(); i++)
            check($sformatf("c_byte%0d", i), {24'd0, c_q[i]}, {24'd0, exp_c[i]});
        check("c_nreads", c_rd_q.size(), 3);
        for (int i = 0; i < 3 && i < c_rd_q.size(); i++)
            check($sformatf("c_rdaddr%0d", i), c_rd_q[i], i);
        $display("frame c: %0d bytes, %0d reads", c_q.size(), c_rd_q.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
